// File: rtl/life_pkg.sv
// Shared constants for the Game-of-Life engine: default rule masks,
// RGB332 colours and the glider loaded at reset.
package life_pkg;

    localparam logic [8:0] BIRTH_B3    = 9'b000001000;
    localparam logic [8:0] SURVIVE_S23 = 9'b000001100;

    localparam logic [7:0] COLOR_LIVE_DEF   = 8'b000_111_00;
    localparam logic [7:0] COLOR_EMPTY_DEF  = 8'b111_111_11;
    localparam logic [7:0] COLOR_CURSOR_DEF = 8'b111_000_00;

    localparam int GLIDER_CELLS = 5;
    localparam int GLIDER_X [GLIDER_CELLS] = '{1, 2, 0, 1, 2};
    localparam int GLIDER_Y [GLIDER_CELLS] = '{0, 1, 2, 2, 2};

endpackage

// File: rtl/life_cell_rule.sv
// Next-state logic for one cell: counts the eight neighbours and looks the
// count up in the birth or survive mask depending on the current state.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [7:0] neighbours,
    input  logic       alive,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       next_alive
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(neighbours[i]);
        end
        next_alive = alive ? survive_mask[count] : birth_mask[count];
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: whole-grid parallel update on a pending step, manual
// and timed stepping, cell editing, stability detection and pixel colouring.
module life_engine
    import life_pkg::*;
#(
    parameter int         BLOCK_SIZE   = 20,
    parameter int         GRID_X       = 32,
    parameter int         GRID_Y       = 24,
    parameter int         WRAP         = 1,
    parameter logic [8:0] BIRTH_MASK   = BIRTH_B3,
    parameter logic [8:0] SURVIVE_MASK = SURVIVE_S23,
    parameter int         STEP_PERIOD  = 25_000_000,
    parameter int         GEN_WIDTH    = 16,
    parameter logic [7:0] COLOR_LIVE   = COLOR_LIVE_DEF,
    parameter logic [7:0] COLOR_EMPTY  = COLOR_EMPTY_DEF,
    parameter logic [7:0] COLOR_CURSOR = COLOR_CURSOR_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        step,
    input  logic                        clear,
    input  logic                        edit_toggle,
    input  logic [$clog2(GRID_X)-1:0]   cursor_x,
    input  logic [$clog2(GRID_Y)-1:0]   cursor_y,
    input  logic [9:0]                  x_position,
    input  logic [8:0]                  y_position,
    input  logic                        inside_video,
    output logic [7:0]                  color,
    output logic [GEN_WIDTH-1:0]        generation,
    output logic                        stable
);

    localparam int XW = $clog2(GRID_X);
    localparam int YW = $clog2(GRID_Y);
    localparam int PW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam bit WRAP_ON = (WRAP != 0);

    typedef logic [GRID_Y-1:0][GRID_X-1:0] grid_t;

    function automatic grid_t seed_grid();
        grid_t g;
        g = '0;
        for (int i = 0; i < GLIDER_CELLS; i++) begin
            g[GLIDER_Y[i]][GLIDER_X[i]] = 1'b1;
        end
        return g;
    endfunction

    localparam grid_t SEED_GRID = seed_grid();

    grid_t                grid_q, grid_d, grid_next;
    logic [PW-1:0]        period_q, period_d;
    logic                 pending_q, pending_d;
    logic [GEN_WIDTH-1:0] generation_q, generation_d;
    logic                 stable_q, stable_d;
    logic [7:0]           color_q, color_d;

    // Neighbour taps resolve at elaboration: wrapped indices, or constant 0 off-grid.
    for (genvar gi = 0; gi < GRID_Y; gi++) begin : g_row
        for (genvar gj = 0; gj < GRID_X; gj++) begin : g_col
            localparam int YM = (gi == 0) ? GRID_Y - 1 : gi - 1;
            localparam int YP = (gi == GRID_Y - 1) ? 0 : gi + 1;
            localparam int XM = (gj == 0) ? GRID_X - 1 : gj - 1;
            localparam int XP = (gj == GRID_X - 1) ? 0 : gj + 1;
            localparam bit UP_OK    = WRAP_ON || (gi > 0);
            localparam bit DOWN_OK  = WRAP_ON || (gi < GRID_Y - 1);
            localparam bit LEFT_OK  = WRAP_ON || (gj > 0);
            localparam bit RIGHT_OK = WRAP_ON || (gj < GRID_X - 1);

            logic [7:0] nb;

            assign nb = {
                (UP_OK && LEFT_OK)    ? grid_q[YM][XM] : 1'b0,
                UP_OK                 ? grid_q[YM][gj] : 1'b0,
                (UP_OK && RIGHT_OK)   ? grid_q[YM][XP] : 1'b0,
                LEFT_OK               ? grid_q[gi][XM] : 1'b0,
                RIGHT_OK              ? grid_q[gi][XP] : 1'b0,
                (DOWN_OK && LEFT_OK)  ? grid_q[YP][XM] : 1'b0,
                DOWN_OK               ? grid_q[YP][gj] : 1'b0,
                (DOWN_OK && RIGHT_OK) ? grid_q[YP][XP] : 1'b0
            };

            life_cell_rule u_rule (
                .neighbours   (nb),
                .alive        (grid_q[gi][gj]),
                .birth_mask   (BIRTH_MASK),
                .survive_mask (SURVIVE_MASK),
                .next_alive   (grid_next[gi][gj])
            );
        end
    end

    logic       tick, step_req, edit_hit;
    logic [9:0] cell_x;
    logic [8:0] cell_y;
    logic       in_grid, cell_live, cell_cursor;

    always_comb begin
        tick     = run && (period_q == PW'(STEP_PERIOD - 1));
        period_d = (run && !tick) ? period_q + PW'(1) : '0;
        step_req = step || (tick && !stable_q);
        edit_hit = (int'(cursor_x) < GRID_X) && (int'(cursor_y) < GRID_Y);

        grid_d       = grid_q;
        generation_d = generation_q;
        stable_d     = stable_q;
        pending_d    = pending_q || step_req;

        if (clear) begin
            grid_d       = '0;
            generation_d = '0;
            stable_d     = 1'b0;
            pending_d    = 1'b0;
        end else if (edit_toggle) begin
            if (edit_hit) begin
                grid_d[cursor_y][cursor_x] = ~grid_q[cursor_y][cursor_x];
            end
            stable_d = 1'b0;
        end else if (pending_q) begin
            // Requests arriving in the execution cycle merge into this step.
            grid_d       = grid_next;
            generation_d = generation_q + GEN_WIDTH'(1);
            stable_d     = (grid_next == grid_q);
            pending_d    = 1'b0;
        end
    end

    always_comb begin
        cell_x      = x_position / 10'(BLOCK_SIZE);
        cell_y      = y_position / 9'(BLOCK_SIZE);
        in_grid     = (int'(cell_x) < GRID_X) && (int'(cell_y) < GRID_Y);
        cell_live   = in_grid && grid_q[cell_y[YW-1:0]][cell_x[XW-1:0]];
        cell_cursor = in_grid && (cell_x[XW-1:0] == cursor_x) && (cell_y[YW-1:0] == cursor_y);

        color_d = COLOR_EMPTY;
        if (!inside_video) begin
            color_d = 8'h00;
        end else if (cell_live) begin
            color_d = COLOR_LIVE;
        end else if (cell_cursor) begin
            color_d = COLOR_CURSOR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grid_q       <= SEED_GRID;
            period_q     <= '0;
            pending_q    <= 1'b0;
            generation_q <= '0;
            stable_q     <= 1'b0;
            color_q      <= 8'h00;
        end else begin
            grid_q       <= grid_d;
            period_q     <= period_d;
            pending_q    <= pending_d;
            generation_q <= generation_d;
            stable_q     <= stable_d;
            color_q      <= color_d;
        end
    end

    assign color      = color_q;
    assign generation = generation_q;
    assign stable     = stable_q;

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: a wrapping and a bounded instance share
// stimulus; expected state per cycle is queued and compared after each edge.
module tb_life_engine;

    localparam int GX = 32;
    localparam int GY = 24;
    typedef logic [GY-1:0][GX-1:0] grid_t;

    localparam logic [8:0] B3       = 9'b000001000;
    localparam logic [8:0] S23      = 9'b000001100;
    localparam logic [7:0] C_LIVE   = 8'b000_111_00;
    localparam logic [7:0] C_EMPTY  = 8'b111_111_11;
    localparam logic [7:0] C_CURSOR = 8'b111_000_00;

    logic       clock = 1'b0;
    logic       reset = 1'b0, run = 1'b0, step = 1'b0, clear = 1'b0, edit_toggle = 1'b0;
    logic [4:0] cursor_x = '0, cursor_y = '0;
    logic [9:0] x_position = '0;
    logic [8:0] y_position = '0;
    logic       inside_video = 1'b0;
    logic [7:0] color, color_nw;
    logic [3:0] generation, generation_nw;
    logic       stable, stable_nw;

    always #5 clock = ~clock;

    life_engine #(.BLOCK_SIZE(20), .GRID_X(GX), .GRID_Y(GY), .WRAP(1),
                  .STEP_PERIOD(4), .GEN_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .clear(clear),
        .edit_toggle(edit_toggle), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .x_position(x_position), .y_position(y_position), .inside_video(inside_video),
        .color(color), .generation(generation), .stable(stable));

    life_engine #(.BLOCK_SIZE(20), .GRID_X(GX), .GRID_Y(GY), .WRAP(0),
                  .STEP_PERIOD(4), .GEN_WIDTH(4)) dut_nw (
        .clock(clock), .reset(reset), .run(run), .step(step), .clear(clear),
        .edit_toggle(edit_toggle), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .x_position(x_position), .y_position(y_position), .inside_video(inside_video),
        .color(color_nw), .generation(generation_nw), .stable(stable_nw));

    typedef struct {
        string      tag;
        grid_t      g;
        grid_t      gn;
        logic [3:0] gen;
        logic       st;
        logic       stn;
        logic [7:0] col;
        logic [7:0] coln;
    } exp_t;

    exp_t  sb[$];
    grid_t m_g, m_gn, p_g, p_gn;
    int    m_gen;
    bit    m_st, m_stn;
    int    tests_run = 0, tests_failed = 0;

    task automatic check_value(input string tag, input logic [767:0] obs, input logic [767:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic grid_t life_next(input grid_t g, input bit wrap);
        grid_t r;
        int n, yy, xx;
        r = '0;
        for (int y = 0; y < GY; y++) begin
            for (int x = 0; x < GX; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        yy = y + dy;
                        xx = x + dx;
                        if (wrap) begin
                            yy = (yy + GY) % GY;
                            xx = (xx + GX) % GX;
                        end
                        if (!(dx == 0 && dy == 0) && yy >= 0 && yy < GY && xx >= 0 && xx < GX)
                            n += int'(g[yy][xx]);
                    end
                end
                r[y][x] = g[y][x] ? S23[n] : B3[n];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] pix_color(input grid_t g, input int x, input int y,
                                             input logic vis, input int cx, input int cy);
        int gx, gy;
        gx = x / 20;
        gy = y / 20;
        if (!vis) return 8'h00;
        if (gx >= GX || gy >= GY) return C_EMPTY;
        if (g[gy][gx]) return C_LIVE;
        if (gx == cx && gy == cy) return C_CURSOR;
        return C_EMPTY;
    endfunction

    function automatic grid_t cells(input int xs[5], input int ys[5]);
        grid_t r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (xs[i] >= 0) r[ys[i]][xs[i]] = 1'b1;
        end
        return r;
    endfunction

    // One clock: queue the expectation for this edge, then compare after it.
    task automatic cycle(input string tag);
        exp_t e;
        e.tag  = tag;
        e.g    = m_g;
        e.gn   = m_gn;
        e.gen  = 4'(m_gen);
        e.st   = m_st;
        e.stn  = m_stn;
        e.col  = reset ? 8'h00 : pix_color(p_g, int'(x_position), int'(y_position),
                                           inside_video, int'(cursor_x), int'(cursor_y));
        e.coln = reset ? 8'h00 : pix_color(p_gn, int'(x_position), int'(y_position),
                                           inside_video, int'(cursor_x), int'(cursor_y));
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_value({e.tag, ".grid"},   dut.grid_q,    e.g);
        check_value({e.tag, ".gridnw"}, dut_nw.grid_q, e.gn);
        check_value({e.tag, ".gen"},    generation,    e.gen);
        check_value({e.tag, ".gennw"},  generation_nw, e.gen);
        check_value({e.tag, ".stable"}, stable,        e.st);
        check_value({e.tag, ".stabnw"}, stable_nw,     e.stn);
        check_value({e.tag, ".color"},  color,         e.col);
        check_value({e.tag, ".colnw"},  color_nw,      e.coln);
        p_g  = m_g;
        p_gn = m_gn;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_g   = cells('{1, 2, 0, 1, 2}, '{0, 1, 2, 2, 2});
        m_gn  = m_g;
        m_gen = 0;
        m_st  = 1'b0;
        m_stn = 1'b0;
        cycle("reset");
        reset = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        m_g   = '0;
        m_gn  = '0;
        m_gen = 0;
        m_st  = 1'b0;
        m_stn = 1'b0;
        cycle("clear");
        clear = 1'b0;
    endtask

    task automatic do_toggle(input int x, input int y);
        cursor_x    = 5'(x);
        cursor_y    = 5'(y);
        edit_toggle = 1'b1;
        if (y < GY) begin
            m_g[y][x]  = ~m_g[y][x];
            m_gn[y][x] = ~m_gn[y][x];
        end
        m_st  = 1'b0;
        m_stn = 1'b0;
        cycle("toggle");
        edit_toggle = 1'b0;
    endtask

    task automatic model_step();
        grid_t nx, nxn;
        nx    = life_next(m_g, 1'b1);
        nxn   = life_next(m_gn, 1'b0);
        m_st  = (nx == m_g);
        m_stn = (nxn == m_gn);
        m_g   = nx;
        m_gn  = nxn;
        m_gen = m_gen + 1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cycle("step_req");
        step = 1'b0;
        model_step();
        cycle("step_exec");
    endtask

    task automatic pixel(input string tag, input int x, input int y, input logic vis,
                         input logic [7:0] want);
        x_position   = 10'(x);
        y_position   = 9'(y);
        inside_video = vis;
        cycle(tag);
        check_value({tag, ".const"}, color, want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        p_g  = '0;
        p_gn = '0;
        @(negedge clock);
        do_reset();
        idle(1, "post_reset");

        // Pixel path against the seeded glider, cursor parked on (5,5).
        cursor_x = 5'd5;
        cursor_y = 5'd5;
        pixel("pix_live",   25,   5,   1'b1, C_LIVE);
        pixel("pix_corner", 639,  479, 1'b1, C_EMPTY);
        pixel("pix_hidden", 25,   5,   1'b0, 8'h00);
        pixel("pix_cursor", 105,  105, 1'b1, C_CURSOR);
        pixel("pix_offgrid", 1000, 5,  1'b1, C_EMPTY);
        inside_video = 1'b0;

        pulse_step();
        check_value("tp_step1", dut.grid_q, cells('{0, 2, 1, 2, 1}, '{1, 1, 2, 2, 3}));
        for (int i = 0; i < 3; i++) pulse_step();
        check_value("tp_step4", dut.grid_q, cells('{2, 3, 1, 2, 3}, '{1, 2, 3, 3, 3}));
        check_value("tp_gen4", generation, 4'd4);

        // Horizontal blinker straddling the left/right edge.
        do_clear();
        do_toggle(31, 0);
        do_toggle(0, 0);
        do_toggle(1, 0);
        pulse_step();
        check_value("wrap_cells", dut.grid_q, cells('{0, 0, 0, -1, -1}, '{23, 0, 1, 0, 0}));
        check_value("nowrap_cells", dut_nw.grid_q, '0);

        // Still-life block under auto-run: one step, then ticks are discarded.
        do_clear();
        do_toggle(5, 5);
        do_toggle(6, 5);
        do_toggle(5, 6);
        do_toggle(6, 6);
        run = 1'b1;
        idle(4, "run_wait");
        model_step();
        cycle("run_tick");
        idle(40, "run_stable");
        run = 1'b0;
        pulse_step();

        // Edit colliding with a pending auto step, then reset mid-run.
        do_reset();
        run = 1'b1;
        idle(4, "run2_wait");
        do_toggle(10, 10);
        model_step();
        cycle("delayed_step");
        idle(2, "run2_wait2");
        do_reset();
        idle(4, "after_reset_wait");
        model_step();
        cycle("after_reset_tick");
        run = 1'b0;

        // Random soup, an ignored off-grid edit, and generation wraparound.
        do_clear();
        for (int i = 0; i < 40; i++) do_toggle(int'($urandom_range(0, 31)), int'($urandom_range(0, 23)));
        do_toggle(3, 30);
        for (int i = 0; i < 18; i++) pulse_step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
